// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- asynchronous serial receiver, 7/8 data bits, optional parity.
//
// Frame: start (low), 7+i_eight data bits LSB first, optional parity bit,
// one stop bit (high). The line is sampled at bit centres, timed by a
// down-counter reloaded with the latched bit time.
//
// Ports
//   i_clk    system clock, all state changes on its rising edge
//   i_rst    asynchronous active-high reset
//   i_rx     serial line (asynchronous, idle high)
//   i_read   one-cycle acknowledge of the held byte
//   i_eight  1 = 8 data bits, 0 = 7 data bits
//   i_pen    parity enable
//   i_ohel   parity sense, 1 = odd, 0 = even
//   i_rate   bit time in i_clk cycles (values below 4 behave as 4)
//   o_byte   last received data (bit 7 is 0 in 7-bit mode)
//   o_rxrdy  a byte is held and not yet read
//   o_perr / o_ferr / o_ovf  parity, framing and overrun flags
//
// Build option
//   UART_RX_SYNC2_EN  defined: i_rx passes a two-flop synchronizer.
//                     undefined: i_rx passes a single register.
module uart_rx #(
    parameter int RATE_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx,
    input  logic              i_read,
    input  logic              i_eight,
    input  logic              i_pen,
    input  logic              i_ohel,
    input  logic [RATE_W-1:0] i_rate,
    output logic [7:0]        o_byte,
    output logic              o_rxrdy,
    output logic              o_perr,
    output logic              o_ferr,
    output logic              o_ovf
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Conditioned serial input
    logic rx_s;
`ifdef UART_RX_SYNC2_EN
    logic rx_meta;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rx_s <= 1'b1;
        else       rx_s <= i_rx;
    end
`endif

    state_t            state;
    logic [RATE_W-1:0] cnt;
    logic [RATE_W-1:0] rate_q;
    logic [3:0]        bit_idx;
    logic [8:0]        shreg;      // data bits, then parity bit right above them
    logic              eight_q, pen_q, ohel_q;
    logic              armed;      // cleared after a low stop bit until the line idles high
    logic              done;       // stop sampled; outputs update next cycle
    logic              stop_low;

    logic [RATE_W-1:0] rate_eff;
    logic              tick;
    logic [3:0]        nbits;
    logic [7:0]        data_w;
    logic              par_bit;
    logic              perr_w;

    assign rate_eff = (i_rate < RATE_W'(4)) ? RATE_W'(4) : i_rate;
    // Sample when the counter reaches 1 and reload with the full rate: one
    // sample every rate cycles, with the half-bit preload landing near centre.
    assign tick     = (cnt == RATE_W'(1));
    assign nbits    = 4'd7 + {3'b000, eight_q} + {3'b000, pen_q};
    assign data_w   = eight_q ? shreg[7:0] : {1'b0, shreg[6:0]};
    assign par_bit  = eight_q ? shreg[8] : shreg[7];
    assign perr_w   = pen_q & (par_bit ^ (^data_w) ^ ohel_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rate_q   <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            eight_q  <= 1'b0;
            pen_q    <= 1'b0;
            ohel_q   <= 1'b0;
            armed    <= 1'b1;
            done     <= 1'b0;
            stop_low <= 1'b0;
            o_byte   <= 8'h00;
            o_rxrdy  <= 1'b0;
            o_perr   <= 1'b0;
            o_ferr   <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            // Completion below overrides this when both land in one cycle.
            if (i_read) begin
                o_rxrdy <= 1'b0;
                o_ovf   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rx_s) armed <= 1'b1;
                    if (armed && !rx_s) begin
                        state   <= START;
                        cnt     <= rate_eff >> 1;
                        rate_q  <= rate_eff;
                        eight_q <= i_eight;
                        pen_q   <= i_pen;
                        ohel_q  <= i_ohel;
                        shreg   <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt   <= rate_q;
                        state <= rx_s ? IDLE : DATA;  // high at half-bit: false start
                    end else begin
                        cnt <= cnt - RATE_W'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt            <= rate_q;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 4'd1;
                        if (bit_idx == nbits - 4'd1) state <= STOP;
                    end else begin
                        cnt <= cnt - RATE_W'(1);
                    end
                end
                STOP: begin
                    if (done) begin
                        done    <= 1'b0;
                        state   <= IDLE;
                        armed   <= !stop_low;
                        o_byte  <= data_w;
                        o_perr  <= perr_w;
                        o_ferr  <= stop_low;
                        o_rxrdy <= 1'b1;
                        o_ovf   <= o_rxrdy & ~i_read;
                    end else if (tick) begin
                        stop_low <= !rx_s;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - RATE_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// compared against a frame-level reference model.
module tb_uart_rx;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx = 1'b1;
    logic        i_read = 1'b0;
    logic        i_eight = 1'b1;
    logic        i_pen = 1'b0;
    logic        i_ohel = 1'b0;
    logic [18:0] i_rate = 19'd109;
    logic [7:0]  o_byte;
    logic        o_rxrdy, o_perr, o_ferr, o_ovf;

    uart_rx #(.RATE_W(19)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .i_read(i_read),
        .i_eight(i_eight), .i_pen(i_pen), .i_ohel(i_ohel), .i_rate(i_rate),
        .o_byte(o_byte), .o_rxrdy(o_rxrdy), .o_perr(o_perr),
        .o_ferr(o_ferr), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state
    logic [7:0] exp_byte = 8'h00;
    logic       exp_rdy = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0, exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".byte"},  o_byte, exp_byte);
        chk({tag, ".rxrdy"}, {7'b0, o_rxrdy}, {7'b0, exp_rdy});
        chk({tag, ".perr"},  {7'b0, o_perr},  {7'b0, exp_perr});
        chk({tag, ".ferr"},  {7'b0, o_ferr},  {7'b0, exp_ferr});
        chk({tag, ".ovf"},   {7'b0, o_ovf},   {7'b0, exp_ovf});
    endtask

    // Frame-level model: what the held registers must show once a frame ends.
    task automatic model_frame(input logic [7:0] d, input logic e8, input logic pe,
                               input logic oh, input logic par, input logic stop);
        logic [7:0] m;
        int ones;
        m    = e8 ? d : (d & 8'h7F);
        ones = $countones(m);
        exp_byte = m;
        exp_perr = pe && (par != logic'((ones + int'(oh)) % 2));
        exp_ferr = !stop;
        exp_ovf  = exp_rdy;
        exp_rdy  = 1'b1;
    endtask

    // Drive the line to v for n cycles; drives always land 1 ns after an edge.
    task automatic hold(input logic v, input int n);
        i_rx = v;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_read();
        i_read = 1'b1;
        @(posedge i_clk);
        #1;
        i_read = 1'b0;
        exp_rdy = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // Sends one frame using the current config; optionally scrambles config
    // while the frame is in flight and restores it afterwards.
    task automatic send_frame(input logic [7:0] d, input int t, input logic par,
                              input logic stop, input int extra_low, input bit scramble);
        logic        e8, pe, oh;
        logic [18:0] rt;
        int          nd;
        e8 = i_eight; pe = i_pen; oh = i_ohel; rt = i_rate;
        nd = e8 ? 8 : 7;
        hold(1'b0, t);
        if (scramble) begin
            i_eight = 1'($urandom);
            i_pen   = 1'($urandom);
            i_ohel  = 1'($urandom);
            i_rate  = 19'($urandom_range(4, 200));
        end
        for (int k = 0; k < nd; k++) hold(d[k], t);
        if (pe) hold(par, t);
        hold(stop, t + extra_low);
        i_eight = e8; i_pen = pe; i_ohel = oh; i_rate = rt;
        hold(1'b1, 6);
    endtask

    initial begin
        logic [7:0] d;
        logic       par, stop;
        int         t;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_all("reset");
        i_rst = 1'b0;
        hold(1'b1, 5);

        // 8N+even parity, correct parity bit
        i_rate = 19'd109; i_eight = 1'b1; i_pen = 1'b1; i_ohel = 1'b0;
        model_frame(8'hAE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'hAE, 109, 1'b1, 1'b1, 0, 1'b0);
        check_all("ae_even");
        do_read();
        check_all("ae_even_read");

        // Same frame, odd sense: parity mismatch
        i_ohel = 1'b1;
        model_frame(8'hAE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'hAE, 109, 1'b1, 1'b1, 0, 1'b0);
        check_all("ae_odd");
        do_read();

        // 7 bits, no parity, low stop extended into a break
        i_eight = 1'b0; i_pen = 1'b0; i_ohel = 1'b0;
        model_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 109, 1'b0, 1'b0, 3 * 109, 1'b0);
        check_all("break");
        do_read();
        check_all("break_read");

        // Short glitch must not be taken as a start bit
        hold(1'b0, 30);
        hold(1'b1, 300);
        check_all("glitch");

        // Overrun
        i_eight = 1'b1;
        model_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h11, 109, 1'b0, 1'b1, 0, 1'b0);
        model_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 109, 1'b0, 1'b1, 0, 1'b0);
        check_all("ovf");
        do_read();
        check_all("ovf_read");

        // Reset mid-DATA, then a clean frame
        hold(1'b0, 109);
        hold(1'b0, 109);
        hold(1'b1, 109);
        i_rst = 1'b1;
        hold(1'b1, 3);
        exp_byte = 8'h00; exp_rdy = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
        check_all("rst_mid");
        i_rst = 1'b0;
        hold(1'b1, 10);
        model_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 109, 1'b0, 1'b1, 0, 1'b0);
        check_all("after_rst");
        do_read();

        // Rate below 4 behaves as 4
        i_rate = 19'd1; i_eight = 1'b1; i_pen = 1'b1; i_ohel = 1'b1;
        model_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'hC3, 4, 1'b1, 1'b1, 0, 1'b0);
        check_all("rate_clamp");

        // Randomized frames with mid-frame config changes and random reads
        for (int it = 0; it < 16; it++) begin
            t       = $urandom_range(16, 60);
            i_rate  = 19'(t);
            i_eight = 1'($urandom);
            i_pen   = 1'($urandom);
            i_ohel  = 1'($urandom);
            d       = 8'($urandom);
            par     = 1'($urandom);
            stop    = ($urandom_range(0, 3) != 0);
            model_frame(d, i_eight, i_pen, i_ohel, par, stop);
            send_frame(d, t, par, stop, 0, 1'b1);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                do_read();
                check_all("rand_read");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
